// File: rtl/car_if.sv
// car_if: command/feedback bundle between the elevator controller and the car hardware.
interface car_if #(
    parameter int SEG_W = 4
);
    logic [1:0]       engine;
    logic [1:0]       door_cmd;
    logic             obstruct;
    logic             load_over;
    logic [SEG_W-1:0] seg_pos;
    logic [2:0]       floor_idx;
    logic             at_floor;
    logic             moving;
    logic             door_closed;
    logic             door_opened;
    logic             overload;
    logic             cmd_reject;
    logic             obstruct_evt;
    logic             fault;

    modport master (
        output engine, door_cmd, obstruct, load_over,
        input  seg_pos, floor_idx, at_floor, moving, door_closed, door_opened,
               overload, cmd_reject, obstruct_evt, fault
    );

    modport slave (
        input  engine, door_cmd, obstruct, load_over,
        output seg_pos, floor_idx, at_floor, moving, door_closed, door_opened,
               overload, cmd_reject, obstruct_evt, fault
    );
endinterface

// File: rtl/car_drive_unit.sv
// car_drive_unit: hoist motor, shaft encoder and door operator answering controller commands.
module car_drive_unit #(
    parameter int FLOORS       = 8,
    parameter int SEG_W        = 4,
    parameter int TRAVEL_TICKS = 16,
    parameter int DOOR_TICKS   = 8
) (
    input logic clk,
    input logic reset,
    car_if.slave bus
);
    localparam int CNT_W = $clog2(TRAVEL_TICKS);
    localparam int DPOS_W = $clog2(DOOR_TICKS + 1);
    localparam logic [SEG_W-1:0]  SEG_TOP   = SEG_W'(2 * (FLOORS - 1));
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [DPOS_W-1:0] DPOS_FULL = DPOS_W'(DOOR_TICKS);
    localparam logic [DPOS_W-1:0] DPOS_NEAR = DPOS_W'(DOOR_TICKS - 1);
    localparam logic [DPOS_W-1:0] DPOS_ONE  = DPOS_W'(1);

    typedef enum logic [1:0] {M_STOP, M_RUN_UP, M_RUN_DN, M_FAULT} mstate_t;
    typedef enum logic [1:0] {D_CLOSED, D_OPENING, D_OPEN, D_CLOSING} dstate_t;

    mstate_t           mstate_q, mstate_d;
    dstate_t           dstate_q, dstate_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DPOS_W-1:0] dpos_q, dpos_d;
    logic              dir_up_q, dir_up_d;
    logic              cmd_reject_q, cmd_reject_d;
    logic              obstruct_evt_q, obstruct_evt_d;
    logic              obs_s1_q, obs_s2_q, load_s1_q, load_s2_q;

    logic at_floor, moving, door_closed, run_up, want_up, want, top, bot, wrap;
    logic open_ok, go_open, go_close, rev, d_up, d_dn, eng_rej;

    assign at_floor    = !seg_q[0] && cnt_q == '0;
    assign moving      = mstate_q == M_RUN_UP || mstate_q == M_RUN_DN;
    assign door_closed = dpos_q == '0;
    assign run_up      = mstate_q == M_RUN_UP;
    assign want_up     = bus.engine == 2'd2;
    assign want        = bus.engine == 2'd1 || want_up;
    assign top         = seg_q == SEG_TOP && cnt_q == '0;
    assign bot         = seg_q == '0 && cnt_q == '0;
    assign wrap        = cnt_q == CNT_LAST;
    assign open_ok     = bus.door_cmd == 2'd1 && at_floor && !moving;

    // A stopped car remembers its last direction so a same-direction restart resumes mid-segment.
    always_comb begin
        mstate_d = mstate_q;
        seg_d    = seg_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        eng_rej  = 1'b0;
        if (mstate_q == M_STOP && want) begin
            if (!door_closed || open_ok) eng_rej = 1'b1;
            else if (want_up ? top : bot) mstate_d = M_FAULT;
            else begin
                mstate_d = want_up ? M_RUN_UP : M_RUN_DN;
                dir_up_d = want_up;
                cnt_d    = want_up == dir_up_q ? cnt_q : '0;
            end
        end else if (moving) begin
            if (want && want_up != run_up) begin
                mstate_d = want_up ? M_RUN_UP : M_RUN_DN;
                dir_up_d = want_up;
                cnt_d    = '0;
            end else if (run_up ? top : bot) mstate_d = want ? M_FAULT : M_STOP;
            else begin
                cnt_d    = wrap ? '0 : cnt_q + 1'b1;
                seg_d    = !wrap ? seg_q : run_up ? seg_q + 1'b1 : seg_q - 1'b1;
                mstate_d = want ? mstate_q : M_STOP;
            end
        end
    end

    assign go_open  = open_ok && (dstate_q == D_CLOSED || dstate_q == D_CLOSING);
    assign go_close = bus.door_cmd == 2'd2 && !obs_s2_q && (dstate_q == D_OPEN || dstate_q == D_OPENING);
    assign rev      = dstate_q == D_CLOSING && obs_s2_q;

    // The door leaf moves one step in the same cycle a stroke starts or reverses.
    always_comb begin
        d_up     = rev || go_open || (dstate_q == D_OPENING && !go_close);
        d_dn     = !d_up && (go_close || dstate_q == D_CLOSING);
        dpos_d   = d_up ? dpos_q + 1'b1 : d_dn ? dpos_q - 1'b1 : dpos_q;
        dstate_d = d_up ? (dpos_q == DPOS_NEAR ? D_OPEN : D_OPENING)
                 : d_dn ? (dpos_q == DPOS_ONE ? D_CLOSED : D_CLOSING) : dstate_q;
    end

    assign cmd_reject_d   = bus.engine == 2'd3 || bus.door_cmd == 2'd3
                          || (bus.door_cmd == 2'd1 && !open_ok) || eng_rej;
    assign obstruct_evt_d = rev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstate_q       <= M_STOP;
            dstate_q       <= D_CLOSED;
            seg_q          <= '0;
            cnt_q          <= '0;
            dpos_q         <= '0;
            dir_up_q       <= 1'b0;
            cmd_reject_q   <= 1'b0;
            obstruct_evt_q <= 1'b0;
            obs_s1_q       <= 1'b0;
            obs_s2_q       <= 1'b0;
            load_s1_q      <= 1'b0;
            load_s2_q      <= 1'b0;
        end else begin
            mstate_q       <= mstate_d;
            dstate_q       <= dstate_d;
            seg_q          <= seg_d;
            cnt_q          <= cnt_d;
            dpos_q         <= dpos_d;
            dir_up_q       <= dir_up_d;
            cmd_reject_q   <= cmd_reject_d;
            obstruct_evt_q <= obstruct_evt_d;
            obs_s1_q       <= bus.obstruct;
            obs_s2_q       <= obs_s1_q;
            load_s1_q      <= bus.load_over;
            load_s2_q      <= load_s1_q;
        end
    end

    assign bus.seg_pos      = seg_q;
    assign bus.floor_idx    = 3'(seg_q >> 1);
    assign bus.at_floor     = at_floor;
    assign bus.moving       = moving;
    assign bus.door_closed  = door_closed;
    assign bus.door_opened  = dpos_q == DPOS_FULL;
    assign bus.overload     = load_s2_q;
    assign bus.cmd_reject   = cmd_reject_q;
    assign bus.obstruct_evt = obstruct_evt_q;
    assign bus.fault        = mstate_q == M_FAULT;
endmodule

// File: tb/tb_car_drive_unit.sv
// tb_car_drive_unit: random commands against a behavioural car model, checked through a scoreboard.
module tb_car_drive_unit;
    localparam int FLOORS = 8;
    localparam int SEG_W  = 4;
    localparam int TT     = 4;
    localparam int DT     = 3;
    localparam int TOP    = 2 * (FLOORS - 1);

    logic clk = 1'b0;
    logic reset;

    car_if #(.SEG_W(SEG_W)) bus();

    car_drive_unit #(
        .FLOORS(FLOORS), .SEG_W(SEG_W), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seg, flr, atf, mov, dcl, dop, ovl, rej, oev, flt;
    } exp_t;

    exp_t sb[$];
    int checks;
    int failures;

    // Car model: position as landing-segment plus progress, direction as -1/0/+1.
    int m_seg, m_cnt, m_run, m_last, m_flt, m_dpos, m_ddir;
    int m_obs1, m_obs2, m_ld1, m_ld2, m_rej, m_oev;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_seg = 0; m_cnt = 0; m_run = 0; m_last = -1; m_flt = 0; m_dpos = 0; m_ddir = 0;
        m_obs1 = 0; m_obs2 = 0; m_ld1 = 0; m_ld2 = 0; m_rej = 0; m_oev = 0;
    endtask

    task automatic model_step(input int e, input int dc, input int ob, input int ld);
        int want;
        int open_ok;
        open_ok = (dc == 1 && m_seg % 2 == 0 && m_cnt == 0 && m_run == 0) ? 1 : 0;
        want = e == 2 ? 1 : e == 1 ? -1 : 0;
        m_rej = (e == 3 || dc == 3 || (dc == 1 && open_ok == 0)) ? 1 : 0;
        m_oev = 0;
        if (m_flt == 0) begin
            if (m_run == 0 && want != 0) begin
                if (m_dpos != 0 || open_ok != 0) m_rej = 1;
                else if (m_cnt == 0 && m_seg == (want > 0 ? TOP : 0)) m_flt = 1;
                else begin
                    if (want != m_last) m_cnt = 0;
                    m_run = want;
                    m_last = want;
                end
            end else if (m_run != 0) begin
                if (want == -m_run) begin
                    m_cnt = 0;
                    m_run = want;
                    m_last = want;
                end else if (m_cnt == 0 && m_seg == (m_run > 0 ? TOP : 0)) begin
                    m_flt = want != 0 ? 1 : 0;
                    m_run = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == TT) begin
                        m_cnt = 0;
                        m_seg += m_run;
                    end
                    if (want == 0) m_run = 0;
                end
            end
        end
        if (m_ddir == -1 && m_obs2 != 0) begin
            m_ddir = 1;
            m_oev = 1;
        end else if (open_ok != 0 && m_ddir != 1 && m_dpos != DT) m_ddir = 1;
        else if (dc == 2 && m_obs2 == 0 && m_dpos != 0 && m_ddir != -1) m_ddir = -1;
        if (m_ddir != 0) begin
            m_dpos += m_ddir;
            if (m_dpos == 0 || m_dpos == DT) m_ddir = 0;
        end
        m_obs2 = m_obs1; m_obs1 = ob;
        m_ld2 = m_ld1; m_ld1 = ld;
    endtask

    task automatic push_exp();
        exp_t x;
        x.seg = m_seg; x.flr = m_seg / 2;
        x.atf = (m_seg % 2 == 0 && m_cnt == 0) ? 1 : 0;
        x.mov = m_run != 0 ? 1 : 0;
        x.dcl = m_dpos == 0 ? 1 : 0;
        x.dop = m_dpos == DT ? 1 : 0;
        x.ovl = m_ld2; x.rej = m_rej; x.oev = m_oev; x.flt = m_flt;
        sb.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                x = sb.pop_front();
                chk("seg_pos", int'(bus.seg_pos), x.seg);
                chk("floor_idx", int'(bus.floor_idx), x.flr);
                chk("at_floor", int'(bus.at_floor), x.atf);
                chk("moving", int'(bus.moving), x.mov);
                chk("door_closed", int'(bus.door_closed), x.dcl);
                chk("door_opened", int'(bus.door_opened), x.dop);
                chk("overload", int'(bus.overload), x.ovl);
                chk("cmd_reject", int'(bus.cmd_reject), x.rej);
                chk("obstruct_evt", int'(bus.obstruct_evt), x.oev);
                chk("fault", int'(bus.fault), x.flt);
            end
        end
    end

    initial begin
        int e_hold, e_val, o_hold, o_val, l_val, dc, r, flt_cycles;
        checks = 0; failures = 0;
        e_hold = 0; e_val = 0; o_hold = 0; o_val = 0; l_val = 0; flt_cycles = 0;
        reset = 1'b0;
        bus.engine = 2'd0; bus.door_cmd = 2'd0; bus.obstruct = 1'b0; bus.load_over = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        model_reset();
        push_exp();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            flt_cycles = m_flt != 0 ? flt_cycles + 1 : 0;
            if (flt_cycles > 8 || $urandom_range(399) == 0) begin
                reset = 1'b0;
                flt_cycles = 0;
                model_reset();
                push_exp();
                #1;
                chk("async_seg_pos", int'(bus.seg_pos), 0);
                chk("async_fault", int'(bus.fault), 0);
                chk("async_moving", int'(bus.moving), 0);
                chk("async_door_closed", int'(bus.door_closed), 1);
            end else begin
                reset = 1'b1;
                if (e_hold == 0) begin
                    r = int'($urandom_range(99));
                    e_val = r < 30 ? 0 : r < 55 ? 1 : r < 93 ? 2 : 3;
                    e_hold = int'($urandom_range(14, 1));
                end
                e_hold--;
                r = int'($urandom_range(99));
                dc = r < 80 ? 0 : r < 90 ? 1 : r < 97 ? 2 : 3;
                if (o_hold == 0) begin
                    o_val = $urandom_range(3) == 0 ? 1 : 0;
                    o_hold = int'($urandom_range(8, 1));
                end
                o_hold--;
                if ($urandom_range(9) == 0) l_val = 1 - l_val;
                bus.engine = 2'(e_val);
                bus.door_cmd = 2'(dc);
                bus.obstruct = o_val[0];
                bus.load_over = l_val[0];
                model_step(e_val, dc, o_val, l_val);
                push_exp();
            end
        end
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
